// File: rtl/hazard_ctrl_unit_if.sv
// Pipeline-register view seen by the hazard control unit: stage instructions and
// control bits in, hold/kill/bubble/forward controls and debug counters out.
interface hazard_ctrl_unit_if;
  localparam int unsigned INS_W = 19;
  localparam int unsigned CNT_W = 16;

  logic [INS_W-1:0] id_ins;
  logic             id_kill;
  logic [INS_W-1:0] ex_ins;
  logic             ex_regwrite;
  logic             ex_memsel;
  logic             ex_regdst;
  logic [1:0]       ex_pcsel;
  logic [INS_W-1:0] mem_ins;
  logic             mem_regwrite;
  logic             mem_regdst;
  logic [INS_W-1:0] wb_ins;
  logic             wb_regwrite;
  logic             wb_regdst;

  logic             pc_hold;
  logic             if_id_hold;
  logic             if_id_kill;
  logic             id_ex_bubble;
  logic [1:0]       fwd_a;
  logic [1:0]       fwd_b;
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] flush_cnt;

  // Pipeline side: publishes stage state, consumes controls.
  modport master (
    output id_ins, id_kill,
    output ex_ins, ex_regwrite, ex_memsel, ex_regdst, ex_pcsel,
    output mem_ins, mem_regwrite, mem_regdst,
    output wb_ins, wb_regwrite, wb_regdst,
    input  pc_hold, if_id_hold, if_id_kill, id_ex_bubble,
    input  fwd_a, fwd_b, stall_cnt, flush_cnt
  );

  // Hazard unit side.
  modport slave (
    input  id_ins, id_kill,
    input  ex_ins, ex_regwrite, ex_memsel, ex_regdst, ex_pcsel,
    input  mem_ins, mem_regwrite, mem_regdst,
    input  wb_ins, wb_regwrite, wb_regdst,
    output pc_hold, if_id_hold, if_id_kill, id_ex_bubble,
    output fwd_a, fwd_b, stall_cnt, flush_cnt
  );
endinterface

// File: rtl/hazard_ctrl_unit.sv
// Hazard control: EX operand forwarding, one-cycle load-use stall and a
// multi-cycle front-end flush after an EX redirect, with saturating debug counters.
module hazard_ctrl_unit #(
  parameter int unsigned FLUSH_CYCLES = 2,
  parameter int unsigned RD_LSB       = 11,
  parameter int unsigned RS_LSB       = 8,
  parameter int unsigned RT_LSB       = 5
) (
  input logic              clk,
  input logic              rst,
  hazard_ctrl_unit_if.slave bus
);

  localparam int unsigned INS_W  = 19;
  localparam int unsigned REG_W  = 3;
  localparam int unsigned FCNT_W = 3;
  localparam int unsigned CNT_W  = 16;
  localparam int unsigned SEL_W  = 2;

  localparam logic [SEL_W-1:0] SEL_RF  = 2'b00;
  localparam logic [SEL_W-1:0] SEL_MEM = 2'b01;
  localparam logic [SEL_W-1:0] SEL_WB  = 2'b10;

  typedef enum logic {
    RUN   = 1'b0,
    FLUSH = 1'b1
  } state_e;

  state_e             state_q, state_d;
  logic [FCNT_W-1:0]  fcnt_q, fcnt_d;
  logic [CNT_W-1:0]   stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0]   flush_cnt_q, flush_cnt_d;

  logic [REG_W-1:0]   id_rs, id_rt, ex_rs, ex_rt;
  logic [REG_W-1:0]   ex_dest, mem_dest, wb_dest;
  logic               redirect;
  logic               load_use;

  logic               pc_hold_c;
  logic               if_id_hold_c;
  logic               if_id_kill_c;
  logic               id_ex_bubble_c;
  logic [SEL_W-1:0]   fwd_a_c;
  logic [SEL_W-1:0]   fwd_b_c;

  // Only the register fields of each instruction are meaningful here.
  logic               unused_ins_bits;
  assign unused_ins_bits = ^{bus.id_ins, bus.ex_ins, bus.mem_ins, bus.wb_ins};

  function automatic logic [REG_W-1:0] dest_of(input logic [INS_W-1:0] ins,
                                               input logic             regdst);
    return regdst ? ins[RD_LSB +: REG_W] : ins[RT_LSB +: REG_W];
  endfunction

  // EX_MEM result is younger than MEM_REG, so it wins when both match.
  function automatic logic [SEL_W-1:0] fwd_sel(input logic [REG_W-1:0] operand,
                                               input logic             mem_we,
                                               input logic [REG_W-1:0] mem_rd,
                                               input logic             wb_we,
                                               input logic [REG_W-1:0] wb_rd);
    if (mem_we && (mem_rd == operand)) begin
      return SEL_MEM;
    end
    if (wb_we && (wb_rd == operand)) begin
      return SEL_WB;
    end
    return SEL_RF;
  endfunction

  assign id_rs    = bus.id_ins[RS_LSB +: REG_W];
  assign id_rt    = bus.id_ins[RT_LSB +: REG_W];
  assign ex_rs    = bus.ex_ins[RS_LSB +: REG_W];
  assign ex_rt    = bus.ex_ins[RT_LSB +: REG_W];
  assign ex_dest  = dest_of(bus.ex_ins,  bus.ex_regdst);
  assign mem_dest = dest_of(bus.mem_ins, bus.mem_regdst);
  assign wb_dest  = dest_of(bus.wb_ins,  bus.wb_regdst);

  assign redirect = |bus.ex_pcsel;
  assign load_use = ~bus.id_kill & bus.ex_regwrite & bus.ex_memsel &
                    ((ex_dest == id_rs) | (ex_dest == id_rt));

  // Next state, counters and same-cycle pipeline controls.
  always_comb begin
    state_d        = state_q;
    fcnt_d         = fcnt_q;
    stall_cnt_d    = stall_cnt_q;
    flush_cnt_d    = flush_cnt_q;
    pc_hold_c      = 1'b0;
    if_id_hold_c   = 1'b0;
    if_id_kill_c   = 1'b0;
    id_ex_bubble_c = 1'b0;
    fwd_a_c        = fwd_sel(ex_rs, bus.mem_regwrite, mem_dest, bus.wb_regwrite, wb_dest);
    fwd_b_c        = fwd_sel(ex_rt, bus.mem_regwrite, mem_dest, bus.wb_regwrite, wb_dest);

    unique case (state_q)
      RUN: begin
        if (redirect) begin
          state_d        = FLUSH;
          fcnt_d         = FCNT_W'(FLUSH_CYCLES - 1);
          if_id_kill_c   = 1'b1;
          id_ex_bubble_c = 1'b1;
          if (flush_cnt_q != '1) begin
            flush_cnt_d = flush_cnt_q + CNT_W'(1);
          end
        end else if (load_use) begin
          pc_hold_c      = 1'b1;
          if_id_hold_c   = 1'b1;
          id_ex_bubble_c = 1'b1;
          if (stall_cnt_q != '1) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
          end
        end
      end
      FLUSH: begin
        // Load-use is irrelevant here: the ID slot is being killed anyway.
        if_id_kill_c   = 1'b1;
        id_ex_bubble_c = 1'b1;
        if (redirect) begin
          fcnt_d = FCNT_W'(FLUSH_CYCLES - 1);
          if (flush_cnt_q != '1) begin
            flush_cnt_d = flush_cnt_q + CNT_W'(1);
          end
        end else if (fcnt_q == '0) begin
          state_d = RUN;
        end else begin
          fcnt_d = fcnt_q - FCNT_W'(1);
        end
      end
      default: begin
        state_d = RUN;
      end
    endcase

    if (rst) begin
      pc_hold_c      = 1'b0;
      if_id_hold_c   = 1'b0;
      if_id_kill_c   = 1'b1;
      id_ex_bubble_c = 1'b1;
      fwd_a_c        = SEL_RF;
      fwd_b_c        = SEL_RF;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= RUN;
      fcnt_q      <= '0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      fcnt_q      <= fcnt_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign bus.pc_hold      = pc_hold_c;
  assign bus.if_id_hold   = if_id_hold_c;
  assign bus.if_id_kill   = if_id_kill_c;
  assign bus.id_ex_bubble = id_ex_bubble_c;
  assign bus.fwd_a        = fwd_a_c;
  assign bus.fwd_b        = fwd_b_c;
  assign bus.stall_cnt    = stall_cnt_q;
  assign bus.flush_cnt    = flush_cnt_q;

endmodule

// File: tb/tb_hazard_ctrl_unit.sv
// Directed bench for hazard_ctrl_unit: forwarding, load-use stall, flush FSM,
// reset abort and counter saturation.
module tb_hazard_ctrl_unit;

  logic clk = 1'b0;
  logic rst;
  int   checks   = 0;
  int   failures = 0;

  hazard_ctrl_unit_if bus_if ();

  hazard_ctrl_unit #(
    .FLUSH_CYCLES(2),
    .RD_LSB      (11),
    .RS_LSB      (8),
    .RT_LSB      (5)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus_if)
  );

  always #5 clk = ~clk;

  function automatic logic [18:0] mk(input logic [2:0] rd, input logic [2:0] rs,
                                     input logic [2:0] rt);
    logic [18:0] ins;
    ins        = '0;
    ins[13:11] = rd;
    ins[10:8]  = rs;
    ins[7:5]   = rt;
    return ins;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_inputs();
    bus_if.id_ins       = '0;
    bus_if.id_kill      = 1'b0;
    bus_if.ex_ins       = '0;
    bus_if.ex_regwrite  = 1'b0;
    bus_if.ex_memsel    = 1'b0;
    bus_if.ex_regdst    = 1'b0;
    bus_if.ex_pcsel     = 2'b00;
    bus_if.mem_ins      = '0;
    bus_if.mem_regwrite = 1'b0;
    bus_if.mem_regdst   = 1'b0;
    bus_if.wb_ins       = '0;
    bus_if.wb_regwrite  = 1'b0;
    bus_if.wb_regdst    = 1'b0;
  endtask

  task automatic set_load_use();
    bus_if.ex_ins      = mk(3'd0, 3'd0, 3'd5);
    bus_if.ex_regwrite = 1'b1;
    bus_if.ex_memsel   = 1'b1;
    bus_if.ex_regdst   = 1'b0;
    bus_if.id_ins      = mk(3'd0, 3'd5, 3'd1);
  endtask

  initial begin
    // Reset: outputs forced even though mem dest 0 matches ex rs 0.
    clear_inputs();
    rst = 1'b1;
    bus_if.mem_regwrite = 1'b1;
    step();
    chk("rst_kill",   32'(bus_if.if_id_kill),   32'd1);
    chk("rst_bubble", 32'(bus_if.id_ex_bubble), 32'd1);
    chk("rst_pchold", 32'(bus_if.pc_hold),      32'd0);
    chk("rst_ifhold", 32'(bus_if.if_id_hold),   32'd0);
    chk("rst_fwd_a",  32'(bus_if.fwd_a),        32'd0);
    chk("rst_stall",  32'(bus_if.stall_cnt),    32'd0);
    chk("rst_flush",  32'(bus_if.flush_cnt),    32'd0);
    rst = 1'b0;
    bus_if.mem_regwrite = 1'b0;
    step();
    chk("run_kill",   32'(bus_if.if_id_kill),   32'd0);
    chk("run_bubble", 32'(bus_if.id_ex_bubble), 32'd0);

    // Load-use masked by id_kill.
    set_load_use();
    bus_if.id_kill = 1'b1;
    #1;
    chk("lu_killed_pchold", 32'(bus_if.pc_hold),      32'd0);
    chk("lu_killed_bubble", 32'(bus_if.id_ex_bubble), 32'd0);
    step();
    chk("lu_killed_cnt", 32'(bus_if.stall_cnt), 32'd0);

    // Real load-use stall: one cycle.
    bus_if.id_kill = 1'b0;
    #1;
    chk("lu_pchold", 32'(bus_if.pc_hold),      32'd1);
    chk("lu_ifhold", 32'(bus_if.if_id_hold),   32'd1);
    chk("lu_bubble", 32'(bus_if.id_ex_bubble), 32'd1);
    chk("lu_kill",   32'(bus_if.if_id_kill),   32'd0);
    step();
    clear_inputs();
    bus_if.ex_ins       = mk(3'd0, 3'd5, 3'd1);
    bus_if.mem_ins      = mk(3'd0, 3'd0, 3'd5);
    bus_if.mem_regwrite = 1'b1;
    #1;
    chk("lu_cnt",        32'(bus_if.stall_cnt),    32'd1);
    chk("post_lu_hold",  32'(bus_if.pc_hold),      32'd0);
    chk("post_lu_bub",   32'(bus_if.id_ex_bubble), 32'd0);
    chk("post_lu_fwd_a", 32'(bus_if.fwd_a),        32'd1);

    // Forwarding priority and operand B.
    clear_inputs();
    bus_if.ex_ins       = mk(3'd0, 3'd3, 3'd4);
    bus_if.mem_ins      = mk(3'd0, 3'd0, 3'd3);
    bus_if.mem_regwrite = 1'b1;
    bus_if.wb_ins       = mk(3'd3, 3'd0, 3'd0);
    bus_if.wb_regdst    = 1'b1;
    bus_if.wb_regwrite  = 1'b1;
    #1;
    chk("fwd_a_mem", 32'(bus_if.fwd_a), 32'd1);
    chk("fwd_b_none", 32'(bus_if.fwd_b), 32'd0);
    bus_if.mem_regwrite = 1'b0;
    #1;
    chk("fwd_a_wb", 32'(bus_if.fwd_a), 32'd2);
    step();
    bus_if.ex_ins       = mk(3'd0, 3'd1, 3'd4);
    bus_if.mem_ins      = mk(3'd4, 3'd0, 3'd0);
    bus_if.mem_regdst   = 1'b1;
    bus_if.mem_regwrite = 1'b1;
    #1;
    chk("fwd_a_rf",  32'(bus_if.fwd_a), 32'd0);
    chk("fwd_b_mem", 32'(bus_if.fwd_b), 32'd1);

    // Redirect: kill for 3 cycles with FLUSH_CYCLES=2; load-use ignored in FLUSH.
    step();
    clear_inputs();
    bus_if.ex_pcsel = 2'b01;
    #1;
    chk("redir_kill",   32'(bus_if.if_id_kill),   32'd1);
    chk("redir_bubble", 32'(bus_if.id_ex_bubble), 32'd1);
    step();
    bus_if.ex_pcsel = 2'b00;
    set_load_use();
    #1;
    chk("flush1_cnt",    32'(bus_if.flush_cnt),  32'd1);
    chk("flush1_kill",   32'(bus_if.if_id_kill), 32'd1);
    chk("flush1_pchold", 32'(bus_if.pc_hold),    32'd0);
    chk("flush1_ifhold", 32'(bus_if.if_id_hold), 32'd0);
    step();
    clear_inputs();
    #1;
    chk("flush2_kill", 32'(bus_if.if_id_kill), 32'd1);
    step();
    chk("flush_done_kill",   32'(bus_if.if_id_kill),   32'd0);
    chk("flush_done_bubble", 32'(bus_if.id_ex_bubble), 32'd0);
    chk("flush_stall_cnt",   32'(bus_if.stall_cnt),    32'd1);

    // Redirect beats load-use.
    set_load_use();
    bus_if.ex_pcsel = 2'b10;
    #1;
    chk("both_kill",   32'(bus_if.if_id_kill),   32'd1);
    chk("both_bubble", 32'(bus_if.id_ex_bubble), 32'd1);
    chk("both_pchold", 32'(bus_if.pc_hold),      32'd0);
    chk("both_ifhold", 32'(bus_if.if_id_hold),   32'd0);
    step();
    clear_inputs();
    bus_if.ex_pcsel = 2'b01;
    #1;
    chk("both_stall_cnt", 32'(bus_if.stall_cnt), 32'd1);
    chk("both_flush_cnt", 32'(bus_if.flush_cnt), 32'd2);
    // Redirect inside FLUSH reloads the down-counter.
    step();
    bus_if.ex_pcsel = 2'b00;
    #1;
    chk("reload_flush_cnt", 32'(bus_if.flush_cnt),  32'd3);
    chk("reload_kill",      32'(bus_if.if_id_kill), 32'd1);

    // Reset mid-flush aborts it.
    rst = 1'b1;
    #1;
    chk("midrst_kill",   32'(bus_if.if_id_kill), 32'd1);
    chk("midrst_pchold", 32'(bus_if.pc_hold),    32'd0);
    step();
    rst = 1'b0;
    #1;
    chk("postrst_kill",  32'(bus_if.if_id_kill),   32'd0);
    chk("postrst_bub",   32'(bus_if.id_ex_bubble), 32'd0);
    chk("postrst_stall", 32'(bus_if.stall_cnt),    32'd0);
    chk("postrst_flush", 32'(bus_if.flush_cnt),    32'd0);

    // Continuous load-use drives stall_cnt to saturation.
    set_load_use();
    for (int i = 0; i < 65534; i++) begin
      step();
    end
    chk("stall_fffe", 32'(bus_if.stall_cnt), 32'h0000_FFFE);
    step();
    chk("stall_ffff", 32'(bus_if.stall_cnt), 32'h0000_FFFF);
    step();
    chk("stall_sat",     32'(bus_if.stall_cnt), 32'h0000_FFFF);
    chk("stall_sat_hold", 32'(bus_if.pc_hold),  32'd1);
    step();
    chk("stall_sat2", 32'(bus_if.stall_cnt), 32'h0000_FFFF);
    clear_inputs();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
